// File: rtl/csr_user_pkg.sv
// Shared definitions for the user-mode CSR sequencer: CSR addresses, op
// encoding, sequencer states and the implemented-address check.
package csr_user_pkg;

  localparam logic [11:0] CSR_USTATUS  = 12'h000;
  localparam logic [11:0] CSR_UIE      = 12'h004;
  localparam logic [11:0] CSR_UTVEC    = 12'h005;
  localparam logic [11:0] CSR_USCRATCH = 12'h040;
  localparam logic [11:0] CSR_UEPC     = 12'h041;
  localparam logic [11:0] CSR_UCAUSE   = 12'h042;
  localparam logic [11:0] CSR_UTVAL    = 12'h043;
  localparam logic [11:0] CSR_UIP      = 12'h044;

  typedef enum logic [1:0] {
    OP_RW   = 2'b00,
    OP_RS   = 2'b01,
    OP_RC   = 2'b10,
    OP_RSVD = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    I_DONE,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_VEC,
    T_DONE
  } csr_state_e;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_USTATUS, CSR_UIE, CSR_UTVEC, CSR_USCRATCH,
      CSR_UEPC, CSR_UCAUSE, CSR_UTVAL, CSR_UIP: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_user_rmw.sv
// Combinational read-modify-write datapath: new CSR value, write enable and
// illegal-access flag for one CSRRW/CSRRS/CSRRC instruction.
module csr_user_rmw
  import csr_user_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 12
) (
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   old_val,
  input  logic [XLEN-1:0]   wsrc,
  input  logic              no_wr,
  input  logic [ADDR_W-1:0] addr,
  output logic [XLEN-1:0]   new_val,
  output logic              wr_en,
  output logic              illegal
);

  csr_op_e op_e;

  always_comb begin
    op_e    = csr_op_e'(op);
    illegal = !csr_implemented(12'(addr)) || (op_e == OP_RSVD);
    new_val = wsrc;
    case (op_e)
      OP_RW:   new_val = wsrc;
      OP_RS:   new_val = old_val | wsrc;
      OP_RC:   new_val = old_val & ~wsrc;
      default: new_val = wsrc;
    endcase
    // x0/zimm=0 only suppresses set/clear; RW always writes.
    wr_en = !illegal && ((op_e == OP_RW) || !no_wr);
  end

endmodule

// File: rtl/csr_user_ctrl.sv
// Sequencer sharing the user CSR file port between execute-stage RMW and
// trap entry. Define CSR_VECTORED_EN to enable vectored utvec targets.
module csr_user_ctrl
  import csr_user_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_req,
  input  logic [1:0]        csr_op,
  input  logic [ADDR_W-1:0] csr_addr,
  input  logic [XLEN-1:0]   csr_wsrc,
  input  logic              csr_no_wr,
  output logic              csr_done,
  output logic [XLEN-1:0]   csr_rdata,
  output logic              csr_illegal,
  input  logic              trap_req,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic [XLEN-1:0]   trap_tval,
  output logic              trap_done,
  output logic [XLEN-1:0]   trap_target,
  output logic              busy,
  output logic              we_csr,
  output logic [ADDR_W-1:0] r_csr_addr,
  output logic [XLEN-1:0]   w_csr_data,
  input  logic [XLEN-1:0]   csr_data
);

  csr_state_e        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wsrc_q, wsrc_d;
  logic              no_wr_q, no_wr_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   target_q, target_d;

  logic [XLEN-1:0]   rmw_new;
  logic              rmw_we;
  logic              rmw_illegal;
  logic [XLEN-1:0]   vec_base;
  logic [XLEN-1:0]   vec_target;

  csr_user_rmw #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_rmw (
    .op      (op_q),
    .old_val (csr_data),
    .wsrc    (wsrc_q),
    .no_wr   (no_wr_q),
    .addr    (addr_q),
    .new_val (rmw_new),
    .wr_en   (rmw_we),
    .illegal (rmw_illegal)
  );

  always_comb begin
    vec_base   = {csr_data[XLEN-1:2], 2'b00};
    vec_target = vec_base;
`ifdef CSR_VECTORED_EN
    if ((csr_data[1:0] == 2'b01) && cause_q[XLEN-1]) begin
      vec_target = vec_base + XLEN'({cause_q[5:0], 2'b00});
    end
`else
    vec_target = vec_base;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wsrc_q    <= '0;
      no_wr_q   <= 1'b0;
      pc_q      <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wsrc_q    <= wsrc_d;
      no_wr_q   <= no_wr_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
      tval_q    <= tval_d;
      rdata_q   <= rdata_d;
      illegal_q <= illegal_d;
      target_q  <= target_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wsrc_d    = wsrc_q;
    no_wr_d   = no_wr_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
    tval_d    = tval_q;
    rdata_d   = rdata_q;
    illegal_d = illegal_q;
    target_d  = target_q;
    case (state_q)
      IDLE: begin
        if (trap_req) begin
          pc_d    = trap_pc;
          cause_d = trap_cause;
          tval_d  = trap_tval;
          state_d = T_EPC;
        end else if (csr_req) begin
          op_d    = csr_op;
          addr_d  = csr_addr;
          wsrc_d  = csr_wsrc;
          no_wr_d = csr_no_wr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rdata_d   = rmw_illegal ? '0 : csr_data;
        illegal_d = rmw_illegal;
        state_d   = I_DONE;
      end
      I_DONE:  state_d = IDLE;
      T_EPC:   state_d = T_CAUSE;
      T_CAUSE: state_d = T_TVAL;
      T_TVAL:  state_d = T_VEC;
      T_VEC: begin
        target_d = vec_target;
        state_d  = T_DONE;
      end
      T_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rst squashes the current cycle's write and done so an aborted sequence
  // leaves only writes committed before the reset cycle.
  always_comb begin
    busy        = (state_q != IDLE);
    we_csr      = 1'b0;
    r_csr_addr  = '0;
    w_csr_data  = '0;
    csr_done    = 1'b0;
    csr_rdata   = '0;
    csr_illegal = 1'b0;
    trap_done   = 1'b0;
    trap_target = '0;
    case (state_q)
      EXEC: begin
        r_csr_addr = addr_q;
        w_csr_data = rmw_new;
        we_csr     = rmw_we && !rst;
      end
      I_DONE: begin
        csr_done    = !rst;
        csr_rdata   = rdata_q;
        csr_illegal = illegal_q;
      end
      T_EPC: begin
        r_csr_addr = ADDR_W'(CSR_UEPC);
        w_csr_data = pc_q;
        we_csr     = !rst;
      end
      T_CAUSE: begin
        r_csr_addr = ADDR_W'(CSR_UCAUSE);
        w_csr_data = cause_q;
        we_csr     = !rst;
      end
      T_TVAL: begin
        r_csr_addr = ADDR_W'(CSR_UTVAL);
        w_csr_data = tval_q;
        we_csr     = !rst;
      end
      T_VEC: r_csr_addr = ADDR_W'(CSR_UTVEC);
      T_DONE: begin
        trap_done   = !rst;
        trap_target = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_user_ctrl.sv
// Self-checking bench for csr_user_ctrl: emulated CSR file, write log and a
// behavioural reference model of the user CSR state.
module tb_csr_user_ctrl;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              csr_req;
  logic [1:0]        csr_op;
  logic [ADDR_W-1:0] csr_addr;
  logic [XLEN-1:0]   csr_wsrc;
  logic              csr_no_wr;
  logic              csr_done;
  logic [XLEN-1:0]   csr_rdata;
  logic              csr_illegal;
  logic              trap_req;
  logic [XLEN-1:0]   trap_pc, trap_cause, trap_tval;
  logic              trap_done;
  logic [XLEN-1:0]   trap_target;
  logic              busy;
  logic              we_csr;
  logic [ADDR_W-1:0] r_csr_addr;
  logic [XLEN-1:0]   w_csr_data;
  logic [XLEN-1:0]   csr_data;

  csr_user_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_req     (csr_req),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wsrc    (csr_wsrc),
    .csr_no_wr   (csr_no_wr),
    .csr_done    (csr_done),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .trap_req    (trap_req),
    .trap_pc     (trap_pc),
    .trap_cause  (trap_cause),
    .trap_tval   (trap_tval),
    .trap_done   (trap_done),
    .trap_target (trap_target),
    .busy        (busy),
    .we_csr      (we_csr),
    .r_csr_addr  (r_csr_addr),
    .w_csr_data  (w_csr_data),
    .csr_data    (csr_data)
  );

  always #5 clk = ~clk;

  // Emulated CSR file and log of every write it receives.
  logic [63:0] mem [4096];
  logic        mem_clear;
  logic [75:0] wlog [$];
  int unsigned csr_done_cnt = 0;
  int unsigned trap_done_cnt = 0;

  assign csr_data = mem[r_csr_addr];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (we_csr) begin
      mem[r_csr_addr] <= w_csr_data;
      wlog.push_back({r_csr_addr, w_csr_data});
    end
  end

  always @(negedge clk) begin
    if (csr_done)  csr_done_cnt++;
    if (trap_done) trap_done_cnt++;
  end

  // Reference model state
  logic [63:0] ref_csr [4096];
  logic [75:0] exp_wlog [$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic is_impl(input logic [11:0] a);
    return a inside {12'h000, 12'h004, 12'h005, 12'h040, 12'h041, 12'h042, 12'h043, 12'h044};
  endfunction

  task automatic check_wlog(input string tag, input int base);
    int n;
    n = wlog.size() - base;
    check({tag, "_nwr"}, 64'(n), 64'(exp_wlog.size()));
    for (int i = 0; i < exp_wlog.size() && i < n; i++) begin
      check({tag, "_wa"}, 64'(wlog[base+i][75:64]), 64'(exp_wlog[i][75:64]));
      check({tag, "_wd"}, wlog[base+i][63:0], exp_wlog[i][63:0]);
    end
  endtask

  task automatic do_csr(input logic [1:0] op, input logic [11:0] addr,
                        input logic [63:0] src, input logic nw, input string tag);
    logic [63:0] old, nv;
    logic        legal, wr, got;
    int          base, k;
    legal = is_impl(addr) && (op != 2'b11);
    old   = legal ? ref_csr[addr] : 64'd0;
    case (op)
      2'b00:   nv = src;
      2'b01:   nv = old | src;
      default: nv = old & ~src;
    endcase
    wr = legal && (op == 2'b00 || !nw);
    exp_wlog.delete();
    if (wr) exp_wlog.push_back({addr, nv});
    @(negedge clk);
    base = wlog.size();
    csr_req = 1'b1; csr_op = op; csr_addr = addr; csr_wsrc = src; csr_no_wr = nw;
    got = 1'b0; k = 0;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk);
      csr_req = 1'b0;
      if (i == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (csr_done) begin
        got = 1'b1; k = i;
        check({tag, "_rdata"}, csr_rdata, old);
        check({tag, "_illegal"}, 64'(csr_illegal), 64'(!legal));
      end
    end
    check({tag, "_lat"}, 64'(k), 64'd2);
    check_wlog(tag, base);
    if (wr) ref_csr[addr] = nv;
  endtask

  task automatic do_trap(input logic [63:0] pc, input logic [63:0] cause,
                         input logic [63:0] tval, input logic with_csr, input string tag);
    logic [63:0] utvec, tgt;
    logic        got;
    int          base, k;
    int unsigned cd0;
    utvec = ref_csr[12'h005];
    tgt   = utvec & ~64'd3;
`ifdef CSR_VECTORED_EN
    if (utvec[1:0] == 2'b01 && cause[63]) tgt = tgt + 64'(cause[5:0]) * 4;
`endif
    exp_wlog.delete();
    exp_wlog.push_back({12'h041, pc});
    exp_wlog.push_back({12'h042, cause});
    exp_wlog.push_back({12'h043, tval});
    @(negedge clk);
    base = wlog.size();
    cd0  = csr_done_cnt;
    trap_req = 1'b1; trap_pc = pc; trap_cause = cause; trap_tval = tval;
    csr_req = with_csr; csr_op = 2'b00; csr_addr = 12'h040; csr_wsrc = 64'h5555; csr_no_wr = 1'b0;
    got = 1'b0; k = 0;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk);
      trap_req = 1'b0;
      csr_req  = (i == 2);  // arrives while busy: must be ignored
      if (i == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (trap_done) begin
        got = 1'b1; k = i;
        check({tag, "_target"}, trap_target, tgt);
      end
    end
    csr_req = 1'b0;
    check({tag, "_lat"}, 64'(k), 64'd5);
    repeat (3) @(negedge clk);
    check({tag, "_nocsr"}, 64'(csr_done_cnt - cd0), 64'd0);
    check_wlog(tag, base);
    ref_csr[12'h041] = pc;
    ref_csr[12'h042] = cause;
    ref_csr[12'h043] = tval;
  endtask

  task automatic do_trap_reset(input logic [63:0] pc);
    int          base;
    int unsigned td0;
    exp_wlog.delete();
    exp_wlog.push_back({12'h041, pc});
    @(negedge clk);
    base = wlog.size();
    td0  = trap_done_cnt;
    trap_req = 1'b1; trap_pc = pc; trap_cause = 64'h7; trap_tval = 64'h99;
    @(negedge clk);
    trap_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", 64'(busy), 64'd0);
    repeat (8) @(negedge clk);
    check("rstmid_nodone", 64'(trap_done_cnt - td0), 64'd0);
    check_wlog("rstmid", base);
    ref_csr[12'h041] = pc;
  endtask

  logic [11:0] impl_tab [8] = '{12'h000, 12'h004, 12'h005, 12'h040,
                                12'h041, 12'h042, 12'h043, 12'h044};

  initial begin
    logic [63:0] r;
    logic [11:0] a;
    rst = 1'b1; mem_clear = 1'b1;
    csr_req = 1'b0; csr_op = '0; csr_addr = '0; csr_wsrc = '0; csr_no_wr = 1'b0;
    trap_req = 1'b0; trap_pc = '0; trap_cause = '0; trap_tval = '0;
    for (int i = 0; i < 4096; i++) ref_csr[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_clear = 1'b0;

    check("rst_busy",        64'(busy), 64'd0);
    check("rst_we",          64'(we_csr), 64'd0);
    check("rst_addr",        64'(r_csr_addr), 64'd0);
    check("rst_wdata",       w_csr_data, 64'd0);
    check("rst_csr_done",    64'(csr_done), 64'd0);
    check("rst_rdata",       csr_rdata, 64'd0);
    check("rst_illegal",     64'(csr_illegal), 64'd0);
    check("rst_trap_done",   64'(trap_done), 64'd0);
    check("rst_trap_target", trap_target, 64'd0);

    do_csr(2'b00, 12'h040, 64'hA5, 1'b0, "rw_first");
    do_csr(2'b00, 12'h040, 64'hF0, 1'b0, "rw_f0");
    do_csr(2'b01, 12'h040, 64'h0F, 1'b0, "rs_0f");
    do_csr(2'b10, 12'h040, 64'h30, 1'b0, "rc_30");
    do_csr(2'b01, 12'h040, 64'h55, 1'b1, "rs_nowr");
    do_csr(2'b10, 12'h040, 64'h55, 1'b1, "rc_nowr");
    do_csr(2'b00, 12'h040, 64'h0,  1'b1, "rw_nowr");
    do_csr(2'b00, 12'h300, 64'h1234, 1'b0, "illegal_addr");
    do_csr(2'b11, 12'h040, 64'h1234, 1'b0, "illegal_op");

    do_csr(2'b00, 12'h005, 64'h8000, 1'b0, "utvec_direct");
    do_trap(64'h1000, 64'h2, 64'hBAD, 1'b1, "trap_direct");
    do_csr(2'b00, 12'h005, 64'h8001, 1'b0, "utvec_vec");
    do_trap(64'h2000, 64'h8000_0000_0000_0004, 64'h0, 1'b0, "trap_vec");
    do_trap(64'h3000, 64'h5, 64'h1, 1'b0, "trap_vec_sync");
    do_trap_reset(64'h4444);
    do_csr(2'b00, 12'h041, 64'h0, 1'b0, "uepc_kept");

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          r = {$urandom, $urandom};
          r[1:0] = 2'($urandom_range(0, 3));
          do_csr(2'b00, 12'h005, r, 1'b0, "rnd_utvec");
        end
        r = {$urandom, $urandom};
        r[63] = $urandom_range(0, 1) == 1;
        do_trap({$urandom, $urandom}, r, {$urandom, $urandom}, 1'($urandom_range(0, 1)), "rnd_trap");
      end else begin
        a = ($urandom_range(0, 9) < 8) ? impl_tab[$urandom_range(0, 7)] : 12'($urandom);
        do_csr(2'($urandom_range(0, 3)), a, {$urandom, $urandom},
               1'($urandom_range(0, 1)), "rnd_csr");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csr_user_ctrl.md
# csr_user_ctrl

Sequencer that owns the single read/write port of the user-mode CSR file and shares it between two requesters: the execute stage (CSRRW/CSRRS/CSRRC read-modify-write) and the trap unit (multi-cycle trap-entry writes of uepc/ucause/utval followed by a utvec read). It sits between the pipeline and the user CSR file. It serialises all CSR traffic, computes RMW results and produces the trap target PC.

## Interface
Parameters:
- XLEN, 64, data width of CSRs and all data ports
- ADDR_W, 12, CSR address width

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- csr_req  in  1  one-cycle instruction request pulse; sampled only when busy=0
- csr_op  in  2  00=RW, 01=RS, 10=RC, 11=reserved (treated as illegal)
- csr_addr  in  12  target CSR address
- csr_wsrc  in  XLEN  rs1 value or zero-extended zimm
- csr_no_wr  in  1  source is x0/zimm=0; suppresses the write for RS/RC only
- csr_done  out  1  one-cycle completion pulse
- csr_rdata  out  XLEN  old CSR value; valid only while csr_done=1
- csr_illegal  out  1  qualifies csr_done: unimplemented address or reserved op
- trap_req  in  1  one-cycle trap-entry pulse; sampled only when busy=0
- trap_pc, trap_cause, trap_tval  in  XLEN each  values for uepc, ucause, utval
- trap_done  out  1  one-cycle completion pulse
- trap_target  out  XLEN  handler PC; valid while trap_done=1
- busy  out  1  high from the cycle after acceptance through the done cycle
- we_csr  out  1  CSR file write enable
- r_csr_addr  out  12  CSR file address (shared by read and write)
- w_csr_data  out  XLEN  CSR file write data
- csr_data  in  XLEN  CSR file combinational read data

## Operation
- FSM states: IDLE, EXEC, I_DONE, T_EPC, T_CAUSE, T_TVAL, T_VEC, T_DONE.
- IDLE: if trap_req, go to T_EPC and latch trap_*. Otherwise, if csr_req, go to EXEC and latch csr_*. Trap wins when both arrive in the same cycle; the losing csr_req is dropped and the requester reissues it.
- Requests arriving while busy=1 are ignored. No preemption once a sequence has started.
- EXEC: drive r_csr_addr=latched addr and latch csr_data as the old value.
  - RW: new = wsrc. RS: new = old | wsrc. RC: new = old & ~wsrc.
  - we_csr=1 unless illegal, or (RS/RC and no_wr). RW always writes.
  - Then go to I_DONE.
- Implemented addresses: 0x000, 0x004, 0x005, 0x040, 0x041, 0x042, 0x043, 0x044. Any other address, or op=11, is illegal: no write, csr_rdata=0, csr_illegal=1.
- T_EPC, T_CAUSE, T_TVAL: write trap_pc to 0x041, trap_cause to 0x042, trap_tval to 0x043, one per cycle with we_csr=1.
- T_VEC: read 0x005 (we_csr=0) and register trap_target. Direct mode: {utvec[63:2],2'b00}.
- I_DONE and T_DONE: pulse the respective done output, then return to IDLE.
- Outside EXEC and T_* states, we_csr, r_csr_addr and w_csr_data are driven to 0.

## Timing
- Reset values: state=IDLE, busy=0, we_csr=0, r_csr_addr=0, w_csr_data=0, csr_done=0, csr_rdata=0, csr_illegal=0, trap_done=0, trap_target=0.
- Instruction path: req in cycle N; EXEC (write) in N+1; csr_done in N+2.
- Trap path: req in N; writes in N+1, N+2, N+3; utvec read in N+4; trap_done in N+5.
- busy=1 from N+1 through the done cycle. The earliest next acceptance is the cycle after done.
- A write issued in EXEC or T_* is visible to CSR reads from the next cycle on.
- rst asserted mid-sequence: return to IDLE next cycle, abort the sequence and emit no done. Writes already committed remain.

## Configuration
- CSR_VECTORED_EN defined: if utvec[1:0]==01 and trap_cause[63]==1, trap_target = {utvec[63:2],2'b00} + 4*trap_cause[5:0]. All other cases use direct mode.
- CSR_VECTORED_EN undefined: utvec[1:0] is ignored and the target is always direct.

## Structure
- Package csr_user_pkg holds:
  - the CSR address constants
  - the op encoding (OP_RW/OP_RS/OP_RC)
  - the FSM state enum
  - the implemented-address check function
- One sub-module, csr_user_rmw: combinational computation of new value, write-enable and illegal flag from op/old/wsrc/no_wr/addr.

## Test plan
- csr_req RW to 0x040 with wsrc=0xA5 after reset -> we_csr in N+1 with w_csr_data=0xA5; csr_done in N+2 with csr_rdata=0.
- uscratch=0xF0, RS with wsrc=0x0F, then RC with wsrc=0x30 -> writes 0xFF then 0xCF; csr_rdata 0xF0 then 0xFF. RS with no_wr=1 -> no we_csr, rdata=0xCF.
- csr_req to 0x300 -> csr_done with csr_illegal=1, rdata=0, no we_csr.
- trap_req and csr_req in the same cycle, pc=0x1000, cause=2, tval=0xBAD, utvec=0x8000 -> writes 0x041/0x042/0x043 in order; trap_done at N+5 with target 0x8000; csr_req dropped.
- With CSR_VECTORED_EN, utvec=0x8001, cause=bit63|4 -> target 0x8010. Without the macro -> target 0x8000.
- rst asserted at N+2 of a trap sequence -> only uepc written; no trap_done; busy=0 after reset.
